// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I-subset core with one shared instruction/data memory port.
// Supports lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, bne, jal.
// Any other encoding stops the core in a terminal halt state until reset.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic        halted,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAdr, StMemRd,
        StMemWb, StMemWr, StAluWb, StBranch, StJal, StHalt
    } state_e;

    state_e state_q, state_d, dec_state;

    logic [31:0] pc_q, oldpc_q, ir_q, a_q, b_q, aluout_q, data_q, target_q;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_rhs, alu_res, rf_wdata;
    logic        rf_we, branch_taken;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Indices at or above NUM_REGS behave like x0: read 0, never written.
    assign rs1_val   = (rs1 != 5'd0 && 32'(rs1) < NUM_REGS) ? regs_q[rs1] : 32'd0;
    assign rs2_val   = (rs2 != 5'd0 && 32'(rs2) < NUM_REGS) ? regs_q[rs2] : 32'd0;
    assign dbg_rdata = (dbg_raddr != 5'd0 && 32'(dbg_raddr) < NUM_REGS) ?
                       regs_q[dbg_raddr] : 32'd0;

    assign branch_taken = (funct3 == 3'b000) ? (a_q == b_q) : (a_q != b_q);

    // Decode: pick the execute state, or halt on any unsupported encoding.
    always_comb begin
        dec_state = StHalt;
        case (opcode)
            OpR: begin
                if (funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})
                    dec_state = StExecR;
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    dec_state = StExecR;
            end
            OpI:      if (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) dec_state = StExecI;
            OpLoad:   if (funct3 == 3'b010) dec_state = StMemAdr;
            OpStore:  if (funct3 == 3'b010) dec_state = StMemAdr;
            OpBranch: if (funct3 == 3'b000 || funct3 == 3'b001) dec_state = StBranch;
            OpJal:    dec_state = StJal;
            default:  dec_state = StHalt;
        endcase
    end

    // ALU: R-type uses B, I-type uses the sign-extended immediate.
    always_comb begin
        alu_rhs = (state_q == StExecI) ? imm_i : b_q;
        case (funct3)
            3'b000:  alu_res = (state_q == StExecR && funct7[5]) ? a_q - alu_rhs : a_q + alu_rhs;
            3'b111:  alu_res = a_q & alu_rhs;
            3'b110:  alu_res = a_q | alu_rhs;
            3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(alu_rhs)};
            default: alu_res = a_q + alu_rhs;
        endcase
    end

    // Next-state logic; memory states advance only on a completed transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: state_d = dec_state;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StMemAdr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StMemWb:  state_d = StFetch;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJal:    state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StHalt;
        endcase
    end

    // Memory port, retire pulse and register-write selection, all decoded from state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        retire    = 1'b0;
        halted    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = aluout_q;
        case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            StMemRd: begin
                mem_req  = 1'b1;
                mem_addr = aluout_q;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = aluout_q;
                mem_wdata = b_q;
                retire    = mem_ready;
            end
            StAluWb: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            StMemWb: begin
                rf_we    = 1'b1;
                rf_wdata = data_q;
                retire   = 1'b1;
            end
            StJal: begin
                rf_we    = 1'b1;
                rf_wdata = oldpc_q + 32'd4;
                retire   = 1'b1;
            end
            StBranch: retire = 1'b1;
            StHalt:   halted = 1'b1;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    // Datapath registers; each latches only in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= 32'd0;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            data_q   <= 32'd0;
            target_q <= 32'd0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        oldpc_q <= pc_q;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                StDecode: begin
                    a_q      <= rs1_val;
                    b_q      <= rs2_val;
                    target_q <= oldpc_q + ((opcode == OpJal) ? imm_j : imm_b);
                end
                StExecR, StExecI: aluout_q <= alu_res;
                StMemAdr: aluout_q <= a_q + ((opcode == OpStore) ? imm_s : imm_i);
                StMemRd:  if (mem_ready) data_q <= mem_rdata;
                StBranch: if (branch_taken) pc_q <= target_q;
                StJal:    pc_q <= target_q;
                default: ;
            endcase
        end
    end

    // Register file write port; x0 and out-of-range indices are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (rf_we && rd != 5'd0 && 32'(rd) < NUM_REGS) begin
            regs_q[rd] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Randomized bench for multi_cycle_cpu: programs are generated as abstract
// instruction records, executed by an instruction-level model, and the core's
// memory traffic, retire latency and register contents are compared against it.
module tb_multi_cycle_cpu;

    localparam logic [31:0] ResetPc = 32'h100;

    typedef enum int {
        KAdd, KSub, KAnd, KOr, KSlt, KAddi, KAndi, KOri, KSlti, KLw, KSw, KBeq, KBne, KJal
    } kind_e;

    typedef struct {
        kind_e       kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_rdata;
    logic [4:0]  dbg_raddr;

    // Environment memory (written by the core) and the model's view of memory.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] m_regs  [32];
    logic [31:0] m_pc;
    instr_t      prog    [64];

    int n_checks = 0;
    int n_fail   = 0;

    multi_cycle_cpu #(
        .RESET_PC (ResetPc),
        .NUM_REGS (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
        instr_t p;
        p.kind = k; p.rd = rd; p.rs1 = rs1; p.rs2 = rs2; p.imm = imm;
        return p;
    endfunction

    function automatic logic [31:0] encode(input instr_t p);
        logic [31:0] im;
        im = p.imm;
        case (p.kind)
            KAdd:  return {7'h00, p.rs2, p.rs1, 3'b000, p.rd, 7'h33};
            KSub:  return {7'h20, p.rs2, p.rs1, 3'b000, p.rd, 7'h33};
            KAnd:  return {7'h00, p.rs2, p.rs1, 3'b111, p.rd, 7'h33};
            KOr:   return {7'h00, p.rs2, p.rs1, 3'b110, p.rd, 7'h33};
            KSlt:  return {7'h00, p.rs2, p.rs1, 3'b010, p.rd, 7'h33};
            KAddi: return {im[11:0], p.rs1, 3'b000, p.rd, 7'h13};
            KAndi: return {im[11:0], p.rs1, 3'b111, p.rd, 7'h13};
            KOri:  return {im[11:0], p.rs1, 3'b110, p.rd, 7'h13};
            KSlti: return {im[11:0], p.rs1, 3'b010, p.rd, 7'h13};
            KLw:   return {im[11:0], p.rs1, 3'b010, p.rd, 7'h03};
            KSw:   return {im[11:5], p.rs2, p.rs1, 3'b010, im[4:0], 7'h23};
            KBeq:  return {im[12], im[10:5], p.rs2, p.rs1, 3'b000, im[4:1], im[11], 7'h63};
            KBne:  return {im[12], im[10:5], p.rs2, p.rs1, 3'b001, im[4:1], im[11], 7'h63};
            KJal:  return {im[20], im[10:1], im[11], im[19:12], p.rd, 7'h6f};
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle with a fixed ready level; the memory answers as a plain RAM.
    task automatic tick(input logic rdy);
        logic        req_s, we_s;
        logic [31:0] a_s, d_s;
        mem_ready = rdy;
        mem_rdata = mem[mem_addr[9:2]];
        req_s = mem_req; we_s = mem_we; a_s = mem_addr; d_s = mem_wdata;
        @(posedge clk);
        if (req_s && rdy && we_s) mem[a_s[9:2]] = d_s;
        @(negedge clk);
    endtask

    // Execute one instruction in the model and follow the core until it retires.
    // mode 0: always ready; 1: random waits; 2: fetch ready, data waits 3 cycles.
    task automatic run_instr(input int mode);
        instr_t      p;
        logic [31:0] v1, v2, wb_val, next_pc, exp_addr, exp_wdata, a_s, d_s;
        logic        wb_en, exp_we, rdy, req_s, we_s;
        int          base, ntr, cycles, waits, nreq, consec;
        bit          done;
        p = prog[m_pc[7:2]];
        v1 = m_regs[p.rs1];
        v2 = m_regs[p.rs2];
        next_pc = m_pc + 32'd4; wb_en = 1'b1; wb_val = 32'd0;
        exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; ntr = 1; base = 4;
        case (p.kind)
            KAdd:  wb_val = v1 + v2;
            KSub:  wb_val = v1 - v2;
            KAnd:  wb_val = v1 & v2;
            KOr:   wb_val = v1 | v2;
            KSlt:  wb_val = ($signed(v1) < $signed(v2)) ? 32'd1 : 32'd0;
            KAddi: wb_val = v1 + p.imm;
            KAndi: wb_val = v1 & p.imm;
            KOri:  wb_val = v1 | p.imm;
            KSlti: wb_val = ($signed(v1) < $signed(p.imm)) ? 32'd1 : 32'd0;
            KLw: begin
                base = 5; ntr = 2; exp_addr = v1 + p.imm; wb_val = ref_mem[exp_addr[9:2]];
            end
            KSw: begin
                wb_en = 1'b0; ntr = 2; exp_we = 1'b1; exp_addr = v1 + p.imm; exp_wdata = v2;
            end
            KBeq: begin
                base = 3; wb_en = 1'b0;
                if (v1 == v2) next_pc = m_pc + p.imm;
            end
            KBne: begin
                base = 3; wb_en = 1'b0;
                if (v1 != v2) next_pc = m_pc + p.imm;
            end
            KJal: begin
                base = 3; wb_val = m_pc + 32'd4; next_pc = m_pc + p.imm;
            end
            default: ;
        endcase

        cycles = 0; waits = 0; nreq = 0; consec = 0; done = 0;
        while (!done && cycles < 64) begin
            cycles++;
            if (halted) begin
                check_eq("unexpected_halt", {31'd0, halted}, 32'd0);
                break;
            end
            if (mem_req) begin
                if (nreq == 0) begin
                    check_eq("fetch_addr", mem_addr, m_pc);
                    check_eq("fetch_we", {31'd0, mem_we}, 32'd0);
                end else if (nreq == 1 && ntr == 2) begin
                    check_eq("data_addr", mem_addr, exp_addr);
                    check_eq("data_we", {31'd0, mem_we}, {31'd0, exp_we});
                    if (exp_we) check_eq("store_data", mem_wdata, exp_wdata);
                end else begin
                    check_eq("xfer_count", nreq, ntr - 1);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (consec >= 3) || ($urandom_range(0, 2) != 0);
                default: rdy = (nreq == 0) || (consec >= 3);
            endcase
            mem_ready = rdy;
            mem_rdata = mem[mem_addr[9:2]];
            #1;
            if (mem_req && !rdy) begin
                waits++; consec++;
            end else begin
                consec = 0;
            end
            if (retire) begin
                done = 1;
                check_eq("retire_latency", cycles, base + waits);
                check_eq("xfers", nreq + int'(mem_req && rdy), ntr);
            end
            req_s = mem_req; we_s = mem_we; a_s = mem_addr; d_s = mem_wdata;
            @(posedge clk);
            if (req_s && rdy) begin
                nreq++;
                if (we_s) mem[a_s[9:2]] = d_s;
            end
            @(negedge clk);
        end
        if (!done) check_eq("retire_timeout", {31'd0, done}, 32'd1);

        if (wb_en && p.rd != 5'd0) m_regs[p.rd] = wb_val;
        if (p.kind == KSw) ref_mem[exp_addr[9:2]] = exp_wdata;
        m_pc = next_pc;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i);
            #1;
            check_eq($sformatf("x%0d", i), dbg_rdata, m_regs[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0; dbg_raddr = 5'd0;

        // Random program at 0x100..0x1FC; data region 0x200..0x3FC.
        for (int i = 0; i < 64; i++) begin
            instr_t      p;
            logic [11:0] r12;
            r12 = 12'($urandom);
            p = mk(kind_e'($urandom_range(0, 13)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), {{20{r12[11]}}, r12});
            case (p.kind)
                KLw, KSw: begin
                    p.rs1 = 5'd0;
                    p.imm = 32'h200 + 32'(4 * $urandom_range(0, 127));
                end
                KBeq, KBne, KJal:
                    p.imm = (32'h100 + 32'(4 * $urandom_range(0, 63))) - (32'h100 + 32'(4 * i));
                default: ;
            endcase
            prog[i] = p;
        end
        prog[0]  = mk(KAddi, 5'd1, 5'd0, 5'd0, 32'd5);
        prog[1]  = mk(KAdd,  5'd2, 5'd1, 5'd1, 32'd0);
        prog[2]  = mk(KSw,   5'd0, 5'd0, 5'd2, 32'h200);
        prog[3]  = mk(KLw,   5'd3, 5'd0, 5'd0, 32'h200);
        prog[63] = mk(KJal,  5'd0, 5'd0, 5'd0, 32'h100 - 32'h1FC);

        for (int i = 0; i < 256; i++) mem[i] = (i >= 128) ? $urandom : 32'd0;
        for (int i = 0; i < 64; i++) mem[64 + i] = encode(prog[i]);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = ResetPc;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First cycle after reset: fetch at RESET_PC, no retire, not halted.
        check_eq("rst_req", {31'd0, mem_req}, 32'd1);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_addr", mem_addr, ResetPc);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_retire", {31'd0, retire}, 32'd0);
        dbg_raddr = 5'd1;
        #1;
        check_eq("rst_x1", dbg_rdata, 32'd0);

        // addi/add with zero wait states, then sw/lw with 3-cycle data waits.
        run_instr(0);
        run_instr(0);
        dbg_raddr = 5'd2;
        #1;
        check_eq("x2_after_add", dbg_rdata, 32'd10);
        run_instr(2);
        run_instr(2);
        dbg_raddr = 5'd3;
        #1;
        check_eq("x3_after_lw", dbg_rdata, 32'd10);

        for (int n = 0; n < 250; n++) run_instr(1);

        mem_ready = 1'b0;
        check_regs();
        for (int i = 128; i < 256; i++) check_eq($sformatf("mem_%0h", i * 4), mem[i], ref_mem[i]);

        // Reset while a store is waiting: the store is abandoned.
        @(negedge clk);
        prog[0] = mk(KAddi, 5'd1, 5'd0, 5'd0, 32'd7);
        prog[1] = mk(KSw,   5'd0, 5'd0, 5'd1, 32'h200);
        mem[64] = encode(prog[0]);
        mem[65] = encode(prog[1]);
        mem[128] = 32'hDEAD_BEEF;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = ResetPc;
        run_instr(0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check_eq("sw_wait_req", {31'd0, mem_req}, 32'd1);
        check_eq("sw_wait_we", {31'd0, mem_we}, 32'd1);
        check_eq("sw_wait_addr", mem_addr, 32'h200);
        check_eq("sw_wait_data", mem_wdata, 32'd7);
        tick(1'b0);
        tick(1'b0);
        check_eq("sw_hold_addr", mem_addr, 32'h200);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        mem_ready = 1'b0;
        check_eq("rst2_req", {31'd0, mem_req}, 32'd1);
        check_eq("rst2_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst2_addr", mem_addr, ResetPc);
        check_eq("rst2_retire", {31'd0, retire}, 32'd0);
        check_eq("rst2_nowrite", mem[128], 32'hDEAD_BEEF);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        check_regs();

        // Illegal all-zero word: halt the cycle after decode, then stay silent.
        @(negedge clk);
        mem[64] = 32'h0000_0000;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("halt_fetch_req", {31'd0, mem_req}, 32'd1);
        tick(1'b1);
        check_eq("halt_decode", {31'd0, halted}, 32'd0);
        tick(1'b1);
        for (int i = 0; i < 6; i++) begin
            check_eq("halted", {31'd0, halted}, 32'd1);
            check_eq("halt_req", {31'd0, mem_req}, 32'd0);
            check_eq("halt_retire", {31'd0, retire}, 32'd0);
            tick(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning the number of architectural registers (legal values 16 or 32; register indices at or above NUM_REGS read as 0 and are never written).
REQ-003 The block SHALL have ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  memory transfer request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  32  byte address; valid while mem_req=1.
- mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  input  32  read data; sampled on the completing edge.
- mem_ready  input  1  transfer completes on any edge where mem_req=1 and mem_ready=1.
- retire  output  1  one-cycle pulse per completed instruction.
- halted  output  1  high while the core is stopped on an illegal instruction.
- dbg_raddr  input  5  register-file debug read index.
- dbg_rdata  output  32  combinational contents of register dbg_raddr.

Function
REQ-004 The block SHALL be a multi-cycle RV32I-subset core sharing one memory port for instructions and data: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, bne, jal.
REQ-005 The FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JAL, HALT.
REQ-006 In FETCH: mem_req=1, mem_we=0, mem_addr=PC; on completion, latch IR=mem_rdata and OLDPC=PC, set PC=PC+4 (mod 2^32), go to DECODE.
REQ-007 In DECODE: latch A=rs1 and B=rs2 register values; latch TARGET=OLDPC+imm (B-type or J-type immediate, sign-extended); next state by opcode; any other opcode or funct encoding goes to HALT.
REQ-008 EXEC_R/EXEC_I: latch ALUOUT=A op B (or A op sign-extended I-imm); go to ALU_WB. ALU_WB: write ALUOUT to rd, pulse retire, go to FETCH.
REQ-009 slt/slti SHALL compare as signed two's complement; sub SHALL wrap modulo 2^32.
REQ-010 MEM_ADR: ALUOUT=A+imm (I-imm for lw, S-imm for sw); go to MEM_RD for lw, MEM_WR for sw.
REQ-011 MEM_RD: read request at ALUOUT; on completion latch DATA and go to MEM_WB. MEM_WB: write DATA to rd, pulse retire, go to FETCH.
REQ-012 MEM_WR: mem_we=1, mem_addr=ALUOUT, mem_wdata=B; on completion pulse retire and go to FETCH.
REQ-013 BRANCH: if (A==B) for beq, or (A!=B) for bne, set PC=TARGET; pulse retire; go to FETCH.
REQ-014 JAL: set PC=TARGET, write OLDPC+4 to rd, pulse retire, go to FETCH.
REQ-015 Zero-wait-state latencies from FETCH entry to retire SHALL be: R/I-ALU 4, lw 5, sw 4, beq/bne 3, jal 3 cycles. Each cycle of mem_ready=0 adds one cycle.
REQ-016 While mem_req=1 and mem_ready=0, mem_we, mem_addr and mem_wdata SHALL hold stable; no architectural state changes.
REQ-017 mem_req SHALL be 0 in all states other than FETCH, MEM_RD and MEM_WR.
REQ-018 Writes to x0 SHALL be discarded; x0 SHALL always read 0, including on dbg_rdata.
REQ-019 Misaligned addresses SHALL be passed to memory unmodified; alignment is not checked.
REQ-020 HALT SHALL be terminal until reset: halted=1, mem_req=0, retire=0.

Reset
REQ-021 When rst=1 at a rising edge: PC=RESET_PC, state=FETCH, all registers, IR, A, B, ALUOUT, DATA, OLDPC and TARGET cleared to 0, retire=0, halted=0; this takes priority over every other event.
REQ-022 Reset asserted while a transfer is pending SHALL abandon it; writes are not performed, and mem_req restarts in FETCH at RESET_PC in the first cycle after rst deasserts.

Verification
REQ-023 RESET_PC=32'h100, release rst -> first cycle: mem_req=1, mem_we=0, mem_addr=32'h100.
REQ-024 addi x1,x0,5 then add x2,x1,x1, mem_ready tied 1 -> retire pulses at cycles 4 and 8; dbg x2=10.
REQ-025 sw x2,8(x0) then lw x3,8(x0), mem_ready held low 3 cycles per transfer -> address 8 and data 10 stable during the wait; x3=10; sw retires at cycle 7; lw retires 8 cycles after the sw retire.
REQ-026 beq x1,x1,+16 at PC 32'h10 -> next fetch at 32'h20; bne x1,x1,+16 -> next fetch at 32'h14; jal x5,-8 at 32'h20 -> x5=32'h24, next fetch at 32'h18.
REQ-027 Instruction word 32'h0000_0000 -> halted=1 the cycle after DECODE; no further mem_req, no retire.
REQ-028 rst pulsed during a sw with mem_ready=0 -> no write completes; next request is a fetch at RESET_PC; all registers read 0.
